floor_request_scheduler: RTL

//  Parametrised successor to the per-floor button-clear decoder. Latches floor call

---
 rtl/floor_request_if.sv | 26 ++
 rtl/floor_request_scheduler.sv | 128 ++++++++++++
 2 files changed

// File: rtl/floor_request_if.sv
// Floor call bus: button/position inputs toward the scheduler, motor/door commands back.
interface floor_request_if #(
  parameter int N_FLOORS = 16,
  parameter int FLOOR_W  = 4
);
  logic [FLOOR_W-1:0]  floor_cur;
  logic                stopped;
  logic [N_FLOORS-1:0] req_set;
  logic                clear_all;
  logic [N_FLOORS-1:0] pending;
  logic                move_up;
  logic                move_down;
  logic                stop_here;
  logic                door_open;
  logic                dir_up;

  modport master (
    output floor_cur, stopped, req_set, clear_all,
    input  pending, move_up, move_down, stop_here, door_open, dir_up
  );

  modport slave (
    input  floor_cur, stopped, req_set, clear_all,
    output pending, move_up, move_down, stop_here, door_open, dir_up
  );
endinterface

// File: rtl/floor_request_scheduler.sv
// Floor call latch plus SCAN scheduler: holds outstanding calls, clears them on
// service, and sequences move/stop/door commands sweep by sweep.
module floor_request_scheduler #(
  parameter int N_FLOORS    = 16,
  parameter int FLOOR_W     = 4,
  parameter int DOOR_CYCLES = 4
) (
  input logic             clk,
  input logic             rst_n,
  floor_request_if.slave  bus
);

  localparam int CNT_W = $clog2(DOOR_CYCLES + 1);
  localparam logic [CNT_W-1:0] DOCK = CNT_W'(DOOR_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, UP, DOWN, SERVE} state_t;

  state_t              state;
  logic [N_FLOORS-1:0] pending;
  logic [N_FLOORS-1:0] pend_nxt;
  logic [N_FLOORS-1:0] hit;
  logic [CNT_W-1:0]    cnt;
  logic                dir_up, move_up, move_down, door_open;
  logic                above, below, any, stop_here, reload, serve;
  logic [FLOOR_W-1:0]  cur;
  logic [31:0]         cur32;

  assign cur   = bus.floor_cur;
  assign cur32 = 32'(cur);
  assign serve = (state == SERVE);

  // Floor one-hot and pending-above/below summary; out-of-range floors hit nothing.
  always_comb begin
    hit   = '0;
    above = 1'b0;
    below = 1'b0;
    for (int i = 0; i < N_FLOORS; i++) begin
      hit[i] = (cur32 == 32'(i));
      if (pending[i] && (32'(i) > cur32)) above = 1'b1;
      if (pending[i] && (32'(i) < cur32)) below = 1'b1;
    end
  end

  assign any       = |pending;
  assign stop_here = |(pending & hit);
  assign reload    = serve && |(bus.req_set & hit);

  // Call register: clear_all beats the arrival clear, which beats a new call.
  assign pend_nxt = bus.clear_all ? '0
                  : ((pending | bus.req_set) & ~(serve ? hit : '0));

  // Scheduler FSM; commands are registered alongside the state they belong to.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      pending   <= '0;
      dir_up    <= 1'b1;
      cnt       <= '0;
      move_up   <= 1'b0;
      move_down <= 1'b0;
      door_open <= 1'b0;
    end else begin
      pending <= pend_nxt;
      case (state)
        IDLE: begin
          if (stop_here && bus.stopped) begin
            state <= SERVE; cnt <= DOCK; door_open <= 1'b1;
          end else if (above) begin
            state <= UP; dir_up <= 1'b1; move_up <= 1'b1;
          end else if (below) begin
            state <= DOWN; dir_up <= 1'b0; move_down <= 1'b1;
          end
        end
        UP: begin
          if (stop_here && bus.stopped) begin
            state <= SERVE; cnt <= DOCK; move_up <= 1'b0; door_open <= 1'b1;
          end else if (!any) begin
            state <= IDLE; move_up <= 1'b0;
          end else if (!above && !stop_here && below) begin
            // nothing left ahead: reverse the sweep
            state <= DOWN; dir_up <= 1'b0; move_up <= 1'b0; move_down <= 1'b1;
          end
        end
        DOWN: begin
          if (stop_here && bus.stopped) begin
            state <= SERVE; cnt <= DOCK; move_down <= 1'b0; door_open <= 1'b1;
          end else if (!any) begin
            state <= IDLE; move_down <= 1'b0;
          end else if (!below && !stop_here && above) begin
            state <= UP; dir_up <= 1'b1; move_down <= 1'b0; move_up <= 1'b1;
          end
        end
        SERVE: begin
          // a new call at this floor while the door is open just keeps it open
          if (reload) begin
            cnt <= DOCK;
          end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            door_open <= 1'b0;
            if (dir_up && above) begin
              state <= UP; move_up <= 1'b1;
            end else if (!dir_up && below) begin
              state <= DOWN; move_down <= 1'b1;
            end else if (above) begin
              state <= UP; dir_up <= 1'b1; move_up <= 1'b1;
            end else if (below) begin
              state <= DOWN; dir_up <= 1'b0; move_down <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE; move_up <= 1'b0; move_down <= 1'b0; door_open <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pending   = pending;
  assign bus.move_up   = move_up;
  assign bus.move_down = move_down;
  assign bus.stop_here = stop_here;
  assign bus.door_open = door_open;
  assign bus.dir_up    = dir_up;

endmodule
